gif_frame_reader: RTL and testbench



---
 rtl/gif_frame_reader.sv | 103 ++++++++++
 tb/tb_gif_frame_reader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gif_frame_reader.sv
// Frame-store read sequencer: one rd strobe per word, two 12-bit pixels per word, frames advance after FRAME_HOLD scans.
// Latency rd->first pixel 2 cycles (>=4 cycles/word); pix_ready low holds EMIT_HI/EMIT_LO with all pixel outputs frozen.
module gif_frame_reader #(
  parameter int SIZE_FRAME = 2047,
  parameter int WIDTH      = 11,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] address,
  output logic [1:0]       frame_sel,
  output logic             rd,
  input  logic [23:0]      rdata,
  output logic [11:0]      pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_sof,
  output logic             pix_eof,
  output logic             frame_done
);

  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, EMIT_HI, EMIT_LO} state_t;

  state_t            state, state_nxt;
  logic [23:0]       word_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              last_addr;
  logic              hold_done;
  logic              lo_accept;

  assign last_addr = (address == WIDTH'(SIZE_FRAME));
  assign hold_done = (hold_cnt == HOLD_W'(FRAME_HOLD - 1));
  assign lo_accept = (state == EMIT_LO) && pix_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pixel outputs decode straight from state so reset clears them without a clock edge.
  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_sof   = 1'b0;
    pix_eof   = 1'b0;
    case (state)
      IDLE:    if (enable) state_nxt = FETCH;
      FETCH: begin
        rd        = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = EMIT_HI;
      EMIT_HI: begin
        pix_valid = 1'b1;
        pix_data  = word_q[23:12];
        pix_sof   = (address == '0);
        if (pix_ready) state_nxt = EMIT_LO;
      end
      EMIT_LO: begin
        pix_valid = 1'b1;
        pix_data  = word_q[11:0];
        pix_eof   = last_addr;
        if (pix_ready) state_nxt = (!last_addr || enable) ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address    <= '0;
      frame_sel  <= '0;
      hold_cnt   <= '0;
      word_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= lo_accept && last_addr;
      if (state == CAPTURE) word_q <= rdata;
      if (state == IDLE && enable) address <= '0;
      // frame_sel only moves here, at the end of a scan.
      if (lo_accept) begin
        if (!last_addr) begin
          address <= address + WIDTH'(1);
        end else begin
          address <= '0;
          if (hold_done) begin
            hold_cnt  <= '0;
            frame_sel <= (frame_sel == 2'(NUM_FRAMES - 1)) ? 2'd0 : frame_sel + 2'd1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gif_frame_reader.sv
// Bench for gif_frame_reader: small 4-word frames, random store contents, scan-level reference model.
module tb_gif_frame_reader;
  localparam int NW   = 4;
  localparam int HOLD = 2;
  localparam int NF   = 4;

  logic        clk, rst, enable, pix_ready;
  logic [1:0]  address, frame_sel, address_b, frame_sel_b;
  logic        rd, rd_b, pix_valid, pix_valid_b, pix_sof, pix_sof_b, pix_eof, pix_eof_b;
  logic        frame_done, frame_done_b;
  logic [23:0] rdata, rdata_b;
  logic [11:0] pix_data, pix_data_b;

  logic [23:0] mem [4][4];
  logic [15:0] acc_q[$];
  logic [3:0]  rd_q[$];
  logic [1:0]  b_scan_q[$];
  int checks, errors, done_cnt, rd_double, stab_err, chk_idx;
  logic rd_prev, rd_b_prev, stall_prev;
  logic [17:0] stall_snap;

  gif_frame_reader #(.SIZE_FRAME(3), .WIDTH(2), .NUM_FRAMES(NF), .FRAME_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .address(address), .frame_sel(frame_sel), .rd(rd),
    .rdata(rdata), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eof(pix_eof), .frame_done(frame_done));

  gif_frame_reader #(.SIZE_FRAME(3), .WIDTH(2), .NUM_FRAMES(3), .FRAME_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .address(address_b), .frame_sel(frame_sel_b), .rd(rd_b),
    .rdata(rdata_b), .pix_data(pix_data_b), .pix_valid(pix_valid_b), .pix_ready(pix_ready),
    .pix_sof(pix_sof_b), .pix_eof(pix_eof_b), .frame_done(frame_done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame store: data appears the cycle after the strobe, zero otherwise.
  always @(posedge clk) begin
    rdata   <= rd   ? mem[frame_sel][address]     : 24'h0;
    rdata_b <= rd_b ? mem[frame_sel_b][address_b] : 24'h0;
  end

  // Recorder: logs handshakes, strobes and stall stability for the tasks to judge.
  always @(negedge clk) begin
    if (rst) begin
      rd_prev = 1'b0; rd_b_prev = 1'b0; stall_prev = 1'b0;
    end else begin
      if (rd && rd_prev) rd_double++;
      if (rd_b && rd_b_prev) rd_double++;
      rd_prev = rd; rd_b_prev = rd_b;
      if (rd) rd_q.push_back({frame_sel, address});
      if (rd_b && address_b == 2'd0) b_scan_q.push_back(frame_sel_b);
      if (frame_done) done_cnt++;
      if (stall_prev && (!pix_valid || {pix_data, pix_sof, pix_eof, address, frame_sel} !== stall_snap))
        stab_err++;
      stall_prev = pix_valid && !pix_ready;
      stall_snap = {pix_data, pix_sof, pix_eof, address, frame_sel};
      if (pix_valid && pix_ready) acc_q.push_back({frame_sel, pix_sof, pix_eof, pix_data});
    end
  end

  // Reference: n-th pixel since reset = {frame, sof, eof, data}.
  function automatic logic [15:0] exp_pix(int n);
    int scan, w, f;
    logic [23:0] wd;
    logic [11:0] d;
    scan = n / (2 * NW);
    w    = n % (2 * NW);
    f    = (scan / HOLD) % NF;
    wd   = mem[f][w / 2];
    d    = (w % 2 == 0) ? wd[23:12] : wd[11:0];
    return {f[1:0], (w == 0), (w == 2 * NW - 1), d};
  endfunction

  function automatic logic [3:0] exp_rd(int n);
    int f, a;
    f = ((n / NW) / HOLD) % NF;
    a = n % NW;
    return {f[1:0], a[1:0]};
  endfunction

  task automatic clear_logs();
    acc_q.delete(); rd_q.delete(); b_scan_q.delete();
    done_cnt = 0; chk_idx = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({address, frame_sel, rd, pix_data, pix_valid, pix_sof, pix_eof, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0d fs=%0d rd=%b data=%h v=%b sof=%b eof=%b done=%b, want all 0",
               address, frame_sel, rd, pix_data, pix_valid, pix_sof, pix_eof, frame_done);
    end
    checks++;
    if ({address_b, frame_sel_b, rd_b, pix_data_b, pix_valid_b, pix_sof_b, pix_eof_b, frame_done_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b: got nonzero outputs, want all 0");
    end
    clear_logs();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (rd !== 1'b0 || pix_valid !== 1'b0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL idle_hold: rd=%b valid=%b strobes=%0d, want 0 0 0", rd, pix_valid, rd_q.size());
    end
  endtask

  task automatic test_basic();
    enable = 1'b1; pix_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rd !== 1'b1 || address !== 2'd0 || frame_sel !== 2'd0) begin
      errors++;
      $display("FAIL first_rd: rd=%b addr=%0d fs=%0d, want 1 0 0", rd, address, frame_sel);
    end
    @(posedge clk); #1;
    checks++;
    if (rd !== 1'b0) begin
      errors++;
      $display("FAIL capture_rd: rd=%b, want 0", rd);
    end
    @(posedge clk); #1;
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 12'hABC || pix_sof !== 1'b1 || pix_eof !== 1'b0) begin
      errors++;
      $display("FAIL first_pixel: v=%b data=%h sof=%b eof=%b, want 1 abc 1 0", pix_valid, pix_data, pix_sof, pix_eof);
    end
    @(posedge clk); #1;
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 12'h123 || pix_sof !== 1'b0) begin
      errors++;
      $display("FAIL second_pixel: v=%b data=%h sof=%b, want 1 123 0", pix_valid, pix_data, pix_sof);
    end
    for (int i = 0; i < 200 && frame_done !== 1'b1; i++) begin @(posedge clk); #1; end
    checks++;
    if (frame_done !== 1'b1 || acc_q.size() != 2 * NW || acc_q[$][12] !== 1'b1) begin
      errors++;
      $display("FAIL first_scan: done=%b pixels=%0d, want 1 %0d with eof last", frame_done, acc_q.size(), 2 * NW);
    end
    checks++;
    if (frame_sel !== 2'd0 || frame_sel_b !== 2'd1) begin
      errors++;
      $display("FAIL frame_after_scan: fs=%0d fs_b=%0d, want 0 1", frame_sel, frame_sel_b);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b, want 0", frame_done);
    end
  endtask

  task automatic test_frame_cycle();
    logic [1:0] seq [9];
    int k, bad, first;
    seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 2000 && done_cnt < 9; i++) begin @(posedge clk); #1; end
    checks++;
    if (done_cnt != 9 || frame_sel !== 2'd0 || frame_sel_b !== 2'd0) begin
      errors++;
      $display("FAIL nine_scans: done=%0d fs=%0d fs_b=%0d, want 9 0 0", done_cnt, frame_sel, frame_sel_b);
    end
    k = 0; bad = 0;
    foreach (acc_q[i]) if (acc_q[i][13]) begin
      if (k < 9 && acc_q[i][15:14] !== seq[k]) bad++;
      k++;
    end
    checks++;
    if (bad != 0 || k < 9) begin
      errors++;
      $display("FAIL frame_sequence: %0d wrong of %0d scans, want 0 wrong of >=9", bad, k);
    end
    bad = 0;
    foreach (b_scan_q[i]) if (b_scan_q[i] !== 2'(i % 3)) bad++;
    checks++;
    if (bad != 0 || b_scan_q.size() < 9) begin
      errors++;
      $display("FAIL hold1_wrap3: %0d wrong of %0d scans, want 0 wrong", bad, b_scan_q.size());
    end
    bad = 0; first = 0;
    for (int i = chk_idx; i < acc_q.size(); i++)
      if (acc_q[i] !== exp_pix(i)) begin if (bad == 0) first = i; bad++; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stream_cycle: %0d bad, first #%0d got %h want %h", bad, first, acc_q[first], exp_pix(first));
    end
    chk_idx = acc_q.size();
  endtask

  task automatic test_backpressure();
    logic [11:0] snap;
    logic [15:0] want;
    for (int i = 0; i < 200 && !(rd === 1'b1 && address === 2'd2); i++) begin @(posedge clk); #1; end
    pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    snap = pix_data;
    want = exp_pix(acc_q.size());
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== want[11:0] || address !== 2'd2) begin
      errors++;
      $display("FAIL stall_entry: v=%b data=%h addr=%0d, want 1 %h 2", pix_valid, pix_data, address, want[11:0]);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (pix_valid !== 1'b1 || pix_data !== snap || rd !== 1'b0 || address !== 2'd2) begin
        errors++;
        $display("FAIL stall_hold[%0d]: v=%b data=%h rd=%b addr=%0d, want 1 %h 0 2", c, pix_valid, pix_data, rd, address, snap);
      end
    end
    pix_ready = 1'b1;
  endtask

  task automatic test_enable_drop();
    int d0, r0;
    for (int i = 0; i < 200 && !(rd === 1'b1 && address === 2'd1); i++) begin @(posedge clk); #1; end
    enable = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 200 && frame_done !== 1'b1; i++) begin @(posedge clk); #1; end
    checks++;
    if (frame_done !== 1'b1 || address !== 2'd0 || acc_q.size() % (2 * NW) != 0 || acc_q[$][12] !== 1'b1) begin
      errors++;
      $display("FAIL drop_completes: done=%b addr=%0d pixels=%0d, want 1 0 multiple of %0d", frame_done, address, acc_q.size(), 2 * NW);
    end
    r0 = rd_q.size();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (rd_q.size() != r0 || pix_valid !== 1'b0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL drop_idle: new_strobes=%0d valid=%b dones=%0d, want 0 0 1", rd_q.size() - r0, pix_valid, done_cnt - d0);
    end
  endtask

  task automatic test_random_ready();
    int bad, first;
    enable = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      pix_ready = ($urandom_range(0, 3) != 0);
    end
    pix_ready = 1'b1;
    checks++;
    if (rd_double != 0) begin
      errors++;
      $display("FAIL rd_back_to_back: %0d occurrences, want 0", rd_double);
    end
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL stall_stability: %0d changes under backpressure, want 0", stab_err);
    end
    bad = 0; first = 0;
    for (int i = chk_idx; i < acc_q.size(); i++)
      if (acc_q[i] !== exp_pix(i)) begin if (bad == 0) first = i; bad++; end
    checks++;
    if (bad != 0 || acc_q.size() < 1000) begin
      errors++;
      $display("FAIL stream_random: %0d bad of %0d, first #%0d got %h want %h", bad, acc_q.size(), first, acc_q[first], exp_pix(first));
    end
    chk_idx = acc_q.size();
    bad = 0; first = 0;
    foreach (rd_q[i]) if (rd_q[i] !== exp_rd(i)) begin if (bad == 0) first = i; bad++; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL strobe_order: %0d bad, first #%0d got %h want %h", bad, first, rd_q[first], exp_rd(first));
    end
  endtask

  task automatic test_rst_mid_scan();
    for (int i = 0; i < 3000 && !(rd === 1'b1 && address === 2'd2 && frame_sel === 2'd2); i++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pix_valid !== 1'b1 || pix_sof !== 1'b0 || pix_eof !== 1'b0 || address !== 2'd2 || frame_sel !== 2'd2) begin
      errors++;
      $display("FAIL reach_emit_lo: v=%b sof=%b eof=%b addr=%0d fs=%0d, want 1 0 0 2 2", pix_valid, pix_sof, pix_eof, address, frame_sel);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({address, frame_sel, rd, pix_data, pix_valid, pix_sof, pix_eof, frame_done} !== '0) begin
      errors++;
      $display("FAIL async_reset: addr=%0d fs=%0d rd=%b data=%h v=%b, want all 0", address, frame_sel, rd, pix_data, pix_valid);
    end
    @(posedge clk); #1;
    clear_logs();
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rd !== 1'b1 || address !== 2'd0 || frame_sel !== 2'd0 || frame_sel_b !== 2'd0) begin
      errors++;
      $display("FAIL restart_rd: rd=%b addr=%0d fs=%0d fs_b=%0d, want 1 0 0 0", rd, address, frame_sel, frame_sel_b);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== mem[0][0][23:12] || pix_sof !== 1'b1) begin
      errors++;
      $display("FAIL restart_pixel: v=%b data=%h sof=%b, want 1 %h 1", pix_valid, pix_data, pix_sof, mem[0][0][23:12]);
    end
  endtask

  initial begin
    checks = 0; errors = 0; rd_double = 0; stab_err = 0;
    rst = 1'b1; enable = 1'b0; pix_ready = 1'b0;
    for (int f = 0; f < 4; f++)
      for (int a = 0; a < 4; a++) mem[f][a] = 24'($urandom);
    mem[0][0] = 24'hABC123;
    clear_logs();
    test_reset();
    test_basic();
    test_frame_cycle();
    test_backpressure();
    test_enable_drop();
    test_random_ready();
    test_rst_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
